// File: rtl/spi_slave.sv
// spi_slave: byte-wide SPI responder, sck oversampled on clk, one byte exchanged per 8-bit frame.
// Optional mid-frame timeout abort is built when SPI_SLAVE_TMO_EN is defined.
module spi_slave #(
   parameter int unsigned TMO_CYC = 64
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       mlb,
   input  logic       sck,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       abort
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e     state;
   logic       sck_s1, sck_s2, sck_prev;
   logic       mosi_s1, mosi_s2;
   logic       rise, fall;
   logic [7:0] hold, tsr, rsr, tsr_load;
   logic       hold_full;
   logic [3:0] nbit;
   logic       tx_hs;

   if (TMO_CYC < 8) begin : g_tmo_check
      $error("TMO_CYC must be at least 8");
   end

`ifdef SPI_SLAVE_TMO_EN
   localparam int unsigned TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_cnt;
`else
   assign abort = 1'b0;
`endif

   assign rise     = sck_s2 & ~sck_prev;
   assign fall     = ~sck_s2 & sck_prev;
   assign tx_ready = ~hold_full;
   assign tx_hs    = tx_valid & ~hold_full;
   assign tsr_load = hold_full ? hold : 8'hFF;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state     <= StIdle;
         sck_s1    <= 1'b1;
         sck_s2    <= 1'b1;
         sck_prev  <= 1'b1;
         mosi_s1   <= 1'b1;
         mosi_s2   <= 1'b1;
         miso      <= 1'b1;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
         hold      <= 8'hFF;
         hold_full <= 1'b0;
         tsr       <= 8'hFF;
         rsr       <= 8'hFF;
         nbit      <= 4'd0;
`ifdef SPI_SLAVE_TMO_EN
         abort     <= 1'b0;
         tmo_cnt   <= '0;
`endif
      end else begin
         sck_s1   <= sck;
         sck_s2   <= sck_s1;
         sck_prev <= sck_s2;
         mosi_s1  <= mosi;
         mosi_s2  <= mosi_s1;
         rx_valid <= 1'b0;
`ifdef SPI_SLAVE_TMO_EN
         abort    <= 1'b0;
`endif
         unique case (state)
            StIdle: begin
               busy <= 1'b0;
               if (fall) begin
                  tsr       <= tsr_load;
                  hold_full <= 1'b0;
                  miso      <= mlb ? tsr_load[7] : tsr_load[0];
                  nbit      <= 4'd0;
                  busy      <= 1'b1;
                  state     <= StShift;
`ifdef SPI_SLAVE_TMO_EN
                  tmo_cnt   <= '0;
`endif
               end
            end
            StShift: begin
               if (rise) begin
                  rsr <= mlb ? {rsr[6:0], mosi_s2} : {mosi_s2, rsr[7:1]};
                  if (nbit != 4'd8) nbit <= nbit + 4'd1;
                  if (nbit == 4'd7) state <= StDone;
               end
               // First bit was already driven when the frame started.
               if (fall && nbit != 4'd0) begin
                  tsr  <= mlb ? {tsr[6:0], 1'b1} : {1'b1, tsr[7:1]};
                  miso <= mlb ? tsr[6] : tsr[1];
               end
`ifdef SPI_SLAVE_TMO_EN
               if (rise || fall) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                  abort <= 1'b1;
                  busy  <= 1'b0;
                  miso  <= 1'b1;
                  state <= StIdle;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            StDone: begin
               rx_data  <= rsr;
               rx_valid <= 1'b1;
               miso     <= 1'b1;
               busy     <= 1'b0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
         // A load in the frame-start cycle lands after the clear, so it is kept.
         if (tx_hs) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: master-side driver, reference model and rx scoreboard.
// Covers the SPI_SLAVE_TMO_EN build as well when that macro is defined.
module tb_spi_slave;

   localparam int unsigned TMO_CYC = 64;
   localparam int          HALF    = 4;

   logic       clk = 1'b0;
   logic       rstb = 1'b0;
   logic       mlb = 1'b1;
   logic       sck = 1'b1;
   logic       mosi = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       miso, tx_ready, rx_valid, busy, abort;
   logic [7:0] rx_data;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] model_hold[$];
   logic [7:0] exp_rx[$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   spi_slave #(.TMO_CYC(TMO_CYC)) dut (
      .clk      (clk),
      .rstb     (rstb),
      .mlb      (mlb),
      .sck      (sck),
      .mosi     (mosi),
      .miso     (miso),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .abort    (abort)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: every rx_valid pulse must match the oldest expected byte.
   always @(negedge clk) begin
      if (rx_valid) begin
         if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_valid_unexpected: rx_data=%02h with no frame outstanding", rx_data);
         end else begin
            mon_exp = exp_rx.pop_front();
            chk("rx_data", {24'h0, rx_data}, {24'h0, mon_exp});
         end
      end
   end

   task automatic load(input logic [7:0] b);
      chk("tx_ready_before_load", {31'h0, tx_ready}, 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      cyc(1);
      tx_valid = 1'b0;
      model_hold.push_back(b);
      chk("tx_ready_after_load", {31'h0, tx_ready}, 32'd0);
   endtask

   // Master side of one frame; called on a negedge, sck high.
   task automatic frame(input logic [7:0] mb, input int nbits, input bit hs,
                        input logic [7:0] hsb);
      logic [7:0] exp_tx;
      logic [7:0] got;
      exp_tx = (model_hold.size() != 0) ? model_hold.pop_front() : 8'hFF;
      if (nbits == 8) exp_rx.push_back(mb);
      got = 8'hFF;
      for (int i = 0; i < nbits; i++) begin
         int bi;
         bi   = mlb ? 7 - i : i;
         sck  = 1'b0;
         mosi = mb[bi];
         if (i == 0 && hs) begin
            // Handshake lands on the same clk edge that acts on the first fall.
            cyc(2);
            tx_data  = hsb;
            tx_valid = 1'b1;
            cyc(1);
            tx_valid = 1'b0;
            model_hold.push_back(hsb);
            cyc(HALF - 3);
         end else begin
            cyc(HALF);
         end
         chk($sformatf("miso_bit%0d", bi), {31'h0, miso}, {31'h0, exp_tx[bi]});
         got[bi] = miso;
         chk("busy_in_frame", {31'h0, busy}, 32'd1);
         if (i == 0) chk("tx_ready_after_fall", {31'h0, tx_ready},
                         (model_hold.size() == 0) ? 32'd1 : 32'd0);
         sck = 1'b1;
         cyc(HALF);
      end
      if (nbits == 8) begin
         cyc(4);
         chk("busy_after_frame", {31'h0, busy}, 32'd0);
         chk("miso_idle", {31'h0, miso}, 32'd1);
         chk("master_rx", {24'h0, got}, {24'h0, exp_tx});
         chk("rx_data_held", {24'h0, rx_data}, {24'h0, mb});
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_miso"}, {31'h0, miso}, 32'd1);
      chk({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
      chk({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'd0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
      chk({tag, "_abort"}, {31'h0, abort}, 32'd0);
      chk({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cyc(3);
      chk_reset_outputs("reset");
      rstb = 1'b1;
      cyc(2);

      // MSB first, held byte returned, 3C received.
      mlb = 1'b1;
      load(8'hA5);
      frame(8'h3C, 8, 1'b0, 8'h00);

      // LSB first, bit order checked per bit inside frame.
      mlb = 1'b0;
      load(8'h81);
      frame(8'h01, 8, 1'b0, 8'h00);

      // Empty hold returns FF; handshake at frame start feeds the next frame.
      mlb = 1'b1;
      frame(8'h55, 8, 1'b1, 8'h12);
      frame(8'h9E, 8, 1'b0, 8'h00);

      // Back-to-back frames with hold reloaded in between.
      load(8'h6B);
      frame(8'h11, 8, 1'b0, 8'h00);
      load(8'hD4);
      frame(8'h22, 8, 1'b0, 8'h00);

      // Reset after the 4th rising sck discards the frame and the pending byte.
      frame(8'hF0, 4, 1'b0, 8'h00);
      load(8'h77);
      rstb = 1'b0;
      cyc(1);
      rstb = 1'b1;
      model_hold.delete();
      chk_reset_outputs("midreset");
      cyc(2);
      frame(8'hC3, 8, 1'b0, 8'h00);

      // sck stalls after 3 bits.
      frame(8'h5A, 3, 1'b0, 8'h00);
`ifdef SPI_SLAVE_TMO_EN
      begin
         bit seen;
         int at;
         seen = 1'b0;
         at   = 0;
         for (int c = HALF; c < 300; c++) begin
            if (abort) begin
               seen = 1'b1;
               at   = c;
               break;
            end
            cyc(1);
         end
         chk("abort_seen", {31'h0, seen}, 32'd1);
         chk("abort_window", {31'h0, (at >= int'(TMO_CYC)) && (at <= int'(TMO_CYC) + 6)}, 32'd1);
         chk("busy_after_abort", {31'h0, busy}, 32'd0);
         chk("miso_after_abort", {31'h0, miso}, 32'd1);
         cyc(1);
         chk("abort_one_cycle", {31'h0, abort}, 32'd0);
      end
`else
      cyc(3 * TMO_CYC);
      chk("stuck_busy", {31'h0, busy}, 32'd1);
      chk("stuck_abort", {31'h0, abort}, 32'd0);
      rstb = 1'b0;
      cyc(1);
      rstb = 1'b1;
      cyc(2);
`endif
      model_hold.delete();

      // Randomised frames against the model.
      for (int n = 0; n < 8; n++) begin
         mlb = 1'($urandom_range(0, 1));
         if (model_hold.size() == 0 && $urandom_range(0, 1) == 1) load(8'($urandom));
         frame(8'($urandom), 8, 1'b0, 8'h00);
      end

      cyc(10);
      chk("rx_queue_drained", exp_rx.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
